// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding for the pipelined bitwise logic unit.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND   = 3'd0;
  localparam op_t OP_OR    = 3'd1;
  localparam op_t OP_XOR   = 3'd2;
  localparam op_t OP_NAND  = 3'd3;
  localparam op_t OP_NOR   = 3'd4;
  localparam op_t OP_XNOR  = 3'd5;
  localparam op_t OP_NOTA  = 3'd6;
  localparam op_t OP_PASSB = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise gate stage: {op,a,b} -> {result,zero,parity}.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  // Even-parity helper: XOR-reduce of a result word.
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // All-zero detector for a result word.
  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return ~|v;
  endfunction

  // Select the bitwise operation; no carries between bit lanes.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (op)
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NAND:  result = ~(a & b);
      OP_NOR:   result = ~(a | b);
      OP_XNOR:  result = ~(a ^ b);
      OP_NOTA:  result = ~a;
      OP_PASSB: result = b;
      default:  result = {WIDTH{1'b0}};
    endcase
  end

  assign zero   = is_zero(result);
  assign parity = parity_of(result);

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with accumulate mode and status flags.
// S1 holds the accepted operands; S2 computes and holds the registered result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  logic             s1_valid_r;
  op_t              s1_op_r;
  logic             s1_acc_en_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [WIDTH-1:0] acc_r;

  logic             s2_load_s;
  logic             s1_move_s;
  logic [WIDTH-1:0] core_a_s;
  logic [WIDTH-1:0] core_result_s;
  logic             core_zero_s;
  logic             core_parity_s;

  // S2 may load when empty or when its beat leaves this cycle; S1 drains into it.
  // in_ready is built only from stage state and out_ready, never from in_valid.
  assign s2_load_s = !out_valid || out_ready;
  assign s1_move_s = s1_valid_r && s2_load_s;
  assign in_ready  = !s1_valid_r || s2_load_s;

  // The accumulator replaces operand A; it always holds the previous beat's result,
  // so back-to-back accumulate beats chain without a bubble.
  assign core_a_s = s1_acc_en_r ? acc_r : s1_a_r;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op     (s1_op_r),
    .a      (core_a_s),
    .b      (s1_b_r),
    .result (core_result_s),
    .zero   (core_zero_s),
    .parity (core_parity_s)
  );

  // Stage 1: capture operands when a beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_op_r     <= OP_AND;
      s1_acc_en_r <= 1'b0;
      s1_a_r      <= {WIDTH{1'b0}};
      s1_b_r      <= {WIDTH{1'b0}};
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_op_r     <= op;
        s1_acc_en_r <= acc_en;
        s1_a_r      <= a;
        s1_b_r      <= b;
      end
    end
  end

  // Stage 2: register the computed result and flags; hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= {WIDTH{1'b0}};
      zero      <= 1'b1;
      parity    <= 1'b0;
    end else if (s2_load_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        result <= core_result_s;
        zero   <= core_zero_s;
        parity <= core_parity_s;
      end
    end
  end

  // Accumulator: tracks every result entering S2; a clear in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= ACC_INIT;
    end else if (acc_clr) begin
      acc_r <= ACC_INIT;
    end else if (s1_move_s) begin
      acc_r <= core_result_s;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8, ACC_INIT=0).
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  op_t          op;
  logic         acc_en;
  logic         acc_clr;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         parity;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         p;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           out_cycs[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           lat_chk = 1'b0;
  bit           rnd_on = 1'b0;
  logic [W-1:0] model_acc = 8'h00;
  logic [W-1:0] t1_exp [8] = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'hA5};

  logic_unit_pipe #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .parity    (parity)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency and bubble checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      3'd0:    ref_op = x & y;
      3'd1:    ref_op = x | y;
      3'd2:    ref_op = x ^ y;
      3'd3:    ref_op = ~(x & y);
      3'd4:    ref_op = ~(x | y);
      3'd5:    ref_op = ~(x ^ y);
      3'd6:    ref_op = ~x;
      default: ref_op = y;
    endcase
  endfunction

  // Output monitor: a beat leaves on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", 32'(result), 32'(mon_e.res));
        chk("zero", 32'(zero), 32'(mon_e.z));
        chk("parity", 32'(parity), 32'(mon_e.p));
        if (lat_chk) chk("latency", 32'(cyc - mon_e.cyc), 32'd2);
        out_cycs.push_back(cyc);
      end
    end
  end

  // Drive one beat, wait for acceptance, push the expected result.
  task automatic send(input op_t o, input logic ae, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] exp_v, input bit use_exp);
    logic [W-1:0] r;
    exp_t         t;
    int           n;
    bit           done;
    op = o; acc_en = ae; a = x; b = y; in_valid = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        n++;
        if (n > 200) begin
          chk("send_timeout", 32'd0, 32'd1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    r = use_exp ? exp_v : ref_op(o, ae ? model_acc : x, y);
    model_acc = r;
    t.res = r; t.z = (r == 8'h00); t.p = ^r; t.cyc = cyc;
    sb_q.push_back(t);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Let every queued beat emerge, then realign to just after a rising edge.
  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = OP_AND; acc_en = 1'b0; acc_clr = 1'b0;
    a = 8'h00; b = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_parity", 32'(parity), 32'd0);
    @(posedge clk); #1;

    // All opcodes with a fixed operand pair, latency 2.
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send(op_t'(i), 1'b0, 8'hC3, 8'hA5, t1_exp[i], 1'b1);
    drain();
    lat_chk = 1'b0;

    // Accumulate chain without bubbles.
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    model_acc = 8'h00;
    out_cycs.delete();
    send(OP_XOR, 1'b1, 8'hFF, 8'h0F, 8'h0F, 1'b1);
    send(OP_XOR, 1'b1, 8'h55, 8'hF0, 8'hFF, 1'b1);
    send(OP_AND, 1'b1, 8'h00, 8'h3C, 8'h3C, 1'b1);
    drain();
    chk("t2_count", 32'(out_cycs.size()), 32'd3);
    if (out_cycs.size() == 3) begin
      chk("t2_gap1", 32'(out_cycs[1] - out_cycs[0]), 32'd1);
      chk("t2_gap2", 32'(out_cycs[2] - out_cycs[1]), 32'd1);
    end

    // Backpressure with a full pipe.
    out_ready = 1'b0;
    out_cycs.delete();
    fork
      begin
        send(OP_AND,  1'b0, 8'hC3, 8'hA5, 8'h00, 1'b0);
        send(OP_OR,   1'b0, 8'h12, 8'h34, 8'h00, 1'b0);
        send(OP_XOR,  1'b0, 8'h5A, 8'hFF, 8'h00, 1'b0);
        send(OP_NAND, 1'b0, 8'hF0, 8'h3C, 8'h00, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        chk("t3_hold", 32'(result), 32'h81);
        chk("t3_accepted", 32'(sb_q.size()), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t3_count", 32'(out_cycs.size()), 32'd4);

    // Status flags.
    send(OP_AND, 1'b0, 8'h0F, 8'hF0, 8'h00, 1'b1);
    drain();
    chk("t4_and_result", 32'(result), 32'h00);
    chk("t4_and_zero", 32'(zero), 32'd1);
    chk("t4_and_parity", 32'(parity), 32'd0);
    send(OP_PASSB, 1'b0, 8'hEE, 8'h07, 8'h07, 1'b1);
    drain();
    chk("t4_pass_result", 32'(result), 32'h07);
    chk("t4_pass_zero", 32'(zero), 32'd0);
    chk("t4_pass_parity", 32'(parity), 32'd1);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(OP_OR, 1'b0, 8'h11, 8'h22, 8'h00, 1'b0);
    send(OP_OR, 1'b0, 8'h44, 8'h88, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_drop", 32'(out_valid), 32'd0);
    sb_q.delete();
    model_acc = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_result", 32'(result), 32'd0);
    chk("t5_zero", 32'(zero), 32'd1);
    chk("t5_parity", 32'(parity), 32'd0);
    @(posedge clk); #1;
    send(OP_XOR, 1'b1, 8'hAA, 8'h01, 8'h01, 1'b1);
    drain();

    // Random ops, operands, accumulate use and handshake gaps.
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
          end
          send(op_t'($urandom_range(7)), 1'($urandom_range(1)), W'($urandom), W'($urandom), 8'h00, 1'b0);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(1));
        end
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
